// File: rtl/scariv_credit_return_master.sv
// Dispatch-side credit counter for one scheduler. Grants all-or-nothing dispatch groups
// against the free-entry count and folds delayed scheduler returns back into it.
module scariv_credit_return_master #(
  parameter  int MAX_CREDITS  = 32,
  parameter  int IN_PORT_SIZE = 2,
  parameter  int RET_LAT      = 1,
  localparam int CW           = $clog2(MAX_CREDITS) + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_disp_valid,
  input  logic [CW-1:0] i_disp_cnt,
  input  logic          i_stall,
  output logic          o_disp_grant,
  output logic          o_credit_full,
  input  logic          i_return_valid,
  input  logic [CW-1:0] i_return_val,
  output logic [CW-1:0] o_credits,
  output logic          o_credit_err
);

  logic [CW-1:0]               r_credits;
  logic                        r_err;
  logic [RET_LAT-1:0]          r_pipe_vld;
  logic [RET_LAT-1:0][CW-1:0]  r_pipe_val;

  logic          cnt_ok;
  logic          over_req;
  logic [CW-1:0] cons;
  logic [CW-1:0] ret;
  logic [CW:0]   nxt;
  logic          sat;

  assign cnt_ok   = (i_disp_cnt <= CW'(IN_PORT_SIZE));
  assign over_req = i_disp_valid & ~cnt_ok;

  assign o_disp_grant = i_disp_valid & ~i_stall & cnt_ok &
                        (i_disp_cnt <= r_credits) & (i_disp_cnt != '0);

  assign cons = o_disp_grant ? i_disp_cnt : '0;
  assign ret  = r_pipe_vld[RET_LAT-1] ? r_pipe_val[RET_LAT-1] : '0;

  // One extra bit so an over-return is caught rather than wrapping.
  assign nxt = {1'b0, r_credits} - {1'b0, cons} + {1'b0, ret};
  assign sat = (nxt > (CW+1)'(MAX_CREDITS));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pipe_vld <= '0;
      r_pipe_val <= '0;
    end else begin
      r_pipe_vld[0] <= i_return_valid;
      r_pipe_val[0] <= i_return_val;
      for (int k = 1; k < RET_LAT; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        r_pipe_val[k] <= r_pipe_val[k-1];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_credits <= CW'(MAX_CREDITS);
      r_err     <= 1'b0;
    end else begin
      r_credits <= sat ? CW'(MAX_CREDITS) : nxt[CW-1:0];
      r_err     <= r_err | sat | over_req;
    end
  end

  assign o_credits     = r_credits;
  assign o_credit_full = (r_credits == '0);
  assign o_credit_err  = r_err;

endmodule

// File: tb/tb_scariv_credit_return_master.sv
// Directed bench for scariv_credit_return_master with a two-stage return pipe;
// expected values are hand-computed per step.
module tb_scariv_credit_return_master;

  localparam int CW = 6;

  logic          i_clk;
  logic          i_reset;
  logic          i_disp_valid;
  logic [CW-1:0] i_disp_cnt;
  logic          i_stall;
  logic          o_disp_grant;
  logic          o_credit_full;
  logic          i_return_valid;
  logic [CW-1:0] i_return_val;
  logic [CW-1:0] o_credits;
  logic          o_credit_err;

  int n_checks = 0;
  int n_errors = 0;

  scariv_credit_return_master #(.MAX_CREDITS(32), .IN_PORT_SIZE(2), .RET_LAT(2)) u_dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_disp_valid   (i_disp_valid),
    .i_disp_cnt     (i_disp_cnt),
    .i_stall        (i_stall),
    .o_disp_grant   (o_disp_grant),
    .o_credit_full  (o_credit_full),
    .i_return_valid (i_return_valid),
    .i_return_val   (i_return_val),
    .o_credits      (o_credits),
    .o_credit_err   (o_credit_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset        = 1'b0;
    i_disp_valid   = 1'b0;
    i_disp_cnt     = '0;
    i_stall        = 1'b0;
    i_return_valid = 1'b0;
    i_return_val   = '0;
    #1 i_reset = 1'b1;
    #1;
    chk("rst_credits", int'(o_credits), 32);
    chk("rst_grant", int'(o_disp_grant), 0);
    chk("rst_full", int'(o_credit_full), 0);
    chk("rst_err", int'(o_credit_err), 0);
    tick();
    i_reset = 1'b0;
    tick();

    // drain 32 credits with 16 groups of 2
    i_disp_valid = 1'b1;
    i_disp_cnt   = 6'd2;
    for (int i = 0; i < 16; i++) begin
      #1 chk("drain_grant", int'(o_disp_grant), 1);
      tick();
      chk("drain_credits", int'(o_credits), 32 - 2*(i+1));
    end
    chk("empty_full", int'(o_credit_full), 1);
    chk("req17_grant", int'(o_disp_grant), 0);
    tick();
    chk("req17_credits", int'(o_credits), 0);

    // return of 3 through the 2-stage pipe; grant check must not see it early
    i_disp_cnt     = 6'd1;
    i_return_valid = 1'b1;
    i_return_val   = 6'd3;
    tick();
    i_return_valid = 1'b0;
    i_return_val   = '0;
    #1;
    chk("lat_e1_credits", int'(o_credits), 0);
    chk("lat_e1_grant", int'(o_disp_grant), 0);
    tick();
    chk("lat_e2_credits", int'(o_credits), 0);
    chk("lat_e2_grant", int'(o_disp_grant), 0);
    tick();
    chk("lat_e3_credits", int'(o_credits), 3);
    chk("lat_e3_full", int'(o_credit_full), 0);

    // 3 -> 1, then cnt=2 refused, cnt=1 granted
    i_disp_cnt = 6'd2;
    #1 chk("to1_grant", int'(o_disp_grant), 1);
    tick();
    chk("to1_credits", int'(o_credits), 1);
    chk("short_grant", int'(o_disp_grant), 0);
    tick();
    chk("short_credits", int'(o_credits), 1);
    i_disp_cnt = 6'd1;
    #1 chk("last_grant", int'(o_disp_grant), 1);
    tick();
    chk("last_credits", int'(o_credits), 0);
    i_disp_valid = 1'b0;

    // refill to 5 while a return of 1 trails one cycle behind
    i_return_valid = 1'b1;
    i_return_val   = 6'd5;
    tick();
    i_return_val   = 6'd1;
    tick();
    i_return_valid = 1'b0;
    i_return_val   = '0;
    tick();
    chk("refill5_credits", int'(o_credits), 5);
    i_disp_valid = 1'b1;
    i_disp_cnt   = 6'd2;
    #1 chk("net_grant", int'(o_disp_grant), 1);
    tick();
    i_disp_valid = 1'b0;
    chk("net_credits", int'(o_credits), 4);
    chk("net_err", int'(o_credit_err), 0);

    // fill back to 32, then over-return
    i_return_valid = 1'b1;
    i_return_val   = 6'd28;
    tick();
    i_return_valid = 1'b0;
    i_return_val   = '0;
    tick();
    tick();
    chk("fill_credits", int'(o_credits), 32);
    chk("fill_err", int'(o_credit_err), 0);
    i_return_valid = 1'b1;
    i_return_val   = 6'd1;
    tick();
    i_return_valid = 1'b0;
    i_return_val   = '0;
    tick();
    tick();
    chk("ovf_credits", int'(o_credits), 32);
    chk("ovf_err", int'(o_credit_err), 1);
    tick();
    tick();
    chk("ovf_sticky", int'(o_credit_err), 1);

    // reset with returns in flight at credits=10
    i_reset = 1'b1;
    #1 i_reset = 1'b0;
    chk("rst2_err", int'(o_credit_err), 0);
    i_disp_valid = 1'b1;
    i_disp_cnt   = 6'd2;
    repeat (11) tick();
    i_disp_valid = 1'b0;
    chk("pre_rst_credits", int'(o_credits), 10);
    i_return_valid = 1'b1;
    i_return_val   = 6'd3;
    tick();
    tick();
    i_return_valid = 1'b0;
    i_return_val   = '0;
    #1 i_reset = 1'b1;
    #1;
    chk("rst_mid_credits", int'(o_credits), 32);
    #1 i_reset = 1'b0;
    tick();
    tick();
    tick();
    chk("post_rst_credits", int'(o_credits), 32);
    chk("post_rst_err", int'(o_credit_err), 0);

    // stall, zero-count, and oversize requests
    i_disp_valid = 1'b1;
    i_disp_cnt   = 6'd1;
    i_stall      = 1'b1;
    #1 chk("stall_grant", int'(o_disp_grant), 0);
    tick();
    chk("stall_credits", int'(o_credits), 32);
    i_stall    = 1'b0;
    i_disp_cnt = 6'd0;
    #1 chk("zero_grant", int'(o_disp_grant), 0);
    tick();
    chk("zero_err", int'(o_credit_err), 0);
    chk("zero_credits", int'(o_credits), 32);
    i_disp_cnt = 6'd3;
    #1 chk("big_grant", int'(o_disp_grant), 0);
    tick();
    i_disp_valid = 1'b0;
    chk("big_err", int'(o_credit_err), 1);
    chk("big_credits", int'(o_credits), 32);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
